// File: rtl/window_5x5_buffer.sv
// -----------------------------------------------------------------------------
// window_5x5_buffer
//
// Streaming line-buffer stage feeding the 5x5 Gaussian operator. Accepts one
// raster-order pixel per handshake and presents the 5x5 neighbourhood that ends
// at the pixel just accepted. A window is emitted only when all 25 taps lie
// inside the current frame. There is no border padding.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   pixel present on 'in'
//   in_ready   out  stage can accept a pixel (combinational)
//   in         in   pixel, raster order, frame starts at (row 0, col 0)
//   out_valid  out  window valid
//   out_ready  in   downstream accepts the window
//   out        out  packed window, byte (r*5+c) at out[(r*5+c)*8 +: 8];
//                   r=0 is the oldest line, c=0 is the leftmost column
//   out_last   out  window belongs to the last pixel of the frame
// -----------------------------------------------------------------------------
module window_5x5_buffer #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH_IN  = 8,
    parameter int DWIDTH_OUT = 8*5*5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH_IN-1:0]  in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH_OUT-1:0] out,
    output logic                  out_last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int TAPS  = 25;

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DWIDTH_IN-1:0] win_q [TAPS];
    logic [DWIDTH_IN-1:0] win_d [TAPS];

    // lb0 holds the previous line, lb3 the line four rows back.
    logic [DWIDTH_IN-1:0] lb0_q [IMG_WIDTH];
    logic [DWIDTH_IN-1:0] lb1_q [IMG_WIDTH];
    logic [DWIDTH_IN-1:0] lb2_q [IMG_WIDTH];
    logic [DWIDTH_IN-1:0] lb3_q [IMG_WIDTH];

    logic [DWIDTH_IN-1:0] new_col [5];
    logic                 accept;
    logic                 col_wrap;
    logic                 row_wrap;
    logic                 pos_valid;
    logic                 pos_last;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_wrap  = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_wrap  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    // The window is fully populated once four earlier lines and four earlier
    // columns of the current line exist; the col gate also keeps windows from
    // straddling a line wrap.
    assign pos_valid = (row_q >= ROW_W'(4)) && (col_q >= COL_W'(4));
    assign pos_last  = pos_valid && row_wrap && col_wrap;

    // Column entering the window: oldest line on top, live pixel at the bottom.
    always_comb begin
        new_col[0] = lb3_q[col_q];
        new_col[1] = lb2_q[col_q];
        new_col[2] = lb1_q[col_q];
        new_col[3] = lb0_q[col_q];
        new_col[4] = in;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        for (int i = 0; i < TAPS; i++) begin
            win_d[i] = win_q[i];
        end

        if (accept) begin
            col_d = col_wrap ? '0 : col_q + COL_W'(1);
            if (col_wrap) begin
                row_d = row_wrap ? '0 : row_q + ROW_W'(1);
            end
            out_valid_d = pos_valid;
            out_last_d  = pos_last;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r*5 + c] = win_q[r*5 + c + 1];
                end
                win_d[r*5 + 4] = new_col[r];
            end
        end else if (out_ready) begin
            // Current window (if any) is consumed and nothing replaces it.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line storage is left unreset: stale contents never reach a valid window
    // because the row counter gates out_valid for the first four lines.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb0_q[col_q] <= in;
            lb1_q[col_q] <= lb0_q[col_q];
            lb2_q[col_q] <= lb1_q[col_q];
            lb3_q[col_q] <= lb2_q[col_q];
        end
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < TAPS; i++) begin
            out[i*DWIDTH_IN +: DWIDTH_IN] = win_q[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
